// File: rtl/alu_arbiter_pkg.sv
// ALU arbiter shared definitions.
// Holds the ALU control codes and the arbiter FSM states.
package alu_arbiter_pkg;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational ALU shared by both requesters.
// Unknown codes give a zero result with err set.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (1'b1)
      (ctl == CTL_AND): result = a & b;
      (ctl == CTL_OR):  result = a | b;
      (ctl == CTL_ADD): result = a + b;
      (ctl == CTL_SUB): result = a - b;
      (ctl == CTL_SLT): result = {{(WIDTH-1){1'b0}}, a < b};
      (ctl == CTL_NOR): result = ~(a | b);
      default:          err    = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU, one operation in flight.
// Round-robin pointer alternates grants under contention.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_t           state;
  logic             ptr;
  logic             id_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_err;
  logic             gnt0;
  logic             gnt1;
  logic             idle;

  assign gnt0 = req0_valid && (!req1_valid || !ptr);
  assign gnt1 = req1_valid && (!req0_valid || ptr);

  // rst_n gating keeps ready low while reset is held
  assign idle       = rst_n && (state == S_IDLE);
  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .ctl    (ctl_q),
    .a      (a_q),
    .b      (b_q),
    .result (res),
    .zero   (res_zero),
    .err    (res_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      ctl_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_ready) begin
            ctl_q <= req0_ctl;
            a_q   <= req0_a;
            b_q   <= req0_b;
            id_q  <= 1'b0;
            ptr   <= 1'b1;
            state <= S_EXEC;
          end else if (req1_ready) begin
            ctl_q <= req1_ctl;
            a_q   <= req1_a;
            b_q   <= req1_b;
            id_q  <= 1'b1;
            ptr   <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= res;
          rsp_zero  <= res_zero;
          rsp_err   <= res_err;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [3:0]  req0_ctl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_ctl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ctl   (req0_ctl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_ctl   (req1_ctl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Single-port operation from IDLE with rsp_ready held low until checked
  task automatic do_op(input logic p, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ez,
                       input logic ee, input string tag);
    if (p) begin
      req1_valid = 1'b1; req1_ctl = c; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_ctl = c; req0_a = a; req0_b = b;
    end
    #1;
    chk1({tag, "_rdy"}, p ? req1_ready : req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF;
    req1_a = 32'hDEAD_BEEF;
    step();
    chk1({tag, "_vld"}, rsp_valid, 1'b1);
    chk1({tag, "_id"}, rsp_id, p);
    chk({tag, "_data"}, rsp_data, ed);
    chk1({tag, "_zero"}, rsp_zero, ez);
    chk1({tag, "_err"}, rsp_err, ee);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd1; req1_b = 32'd1;
    rsp_ready = 1'b0;
    #3;
    chk1("rst_rdy0", req0_ready, 1'b0);
    chk1("rst_rdy1", req1_ready, 1'b0);
    chk1("rst_vld", rsp_valid, 1'b0);
    chk1("rst_id", rsp_id, 1'b0);
    chk("rst_data", rsp_data, 32'd0);
    chk1("rst_zero", rsp_zero, 1'b0);
    chk1("rst_err", rsp_err, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // single request, latency and input isolation
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    chk1("s_rdy0", req0_ready, 1'b1);
    chk1("s_rdy1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0; req0_a = 32'd100; req0_ctl = 4'd0;
    chk1("s_rdy_exec", req0_ready, 1'b0);
    chk1("s_vld_exec", rsp_valid, 1'b0);
    step();
    chk1("s_vld", rsp_valid, 1'b1);
    chk1("s_id", rsp_id, 1'b0);
    chk("s_data", rsp_data, 32'd12);
    chk1("s_zero", rsp_zero, 1'b0);
    chk1("s_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1("s_done", rsp_valid, 1'b0);

    // contention right after reset
    pulse_reset();
    req0_valid = 1'b1; req0_ctl = 4'd6; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctl = 4'd1;
    req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
    rsp_ready = 1'b1;
    #1;
    chk1("c_rdy0", req0_ready, 1'b1);
    chk1("c_rdy1", req1_ready, 1'b0);
    step();
    step();
    chk1("c1_vld", rsp_valid, 1'b1);
    chk1("c1_id", rsp_id, 1'b0);
    chk("c1_data", rsp_data, 32'd0);
    chk1("c1_zero", rsp_zero, 1'b1);
    chk1("c1_rdy1", req1_ready, 1'b0);
    step();
    chk1("c2_rdy1", req1_ready, 1'b1);
    chk1("c2_rdy0", req0_ready, 1'b0);
    step();
    step();
    chk1("c2_vld", rsp_valid, 1'b1);
    chk1("c2_id", rsp_id, 1'b1);
    chk("c2_data", rsp_data, 32'h0000_00FF);
    chk1("c2_zero", rsp_zero, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;

    // backpressure with req1 waiting
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd0; req1_a = 32'hF; req1_b = 32'h3;
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_vld", rsp_valid, 1'b1);
      chk1("bp_id", rsp_id, 1'b0);
      chk("bp_data", rsp_data, 32'd2);
      chk1("bp_rdy1", req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk1("bp_rdy1_acc", req1_ready, 1'b0);
    step();
    rsp_ready = 1'b0;
    chk1("bp_vld_off", rsp_valid, 1'b0);
    chk1("bp_rdy1_go", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    chk1("bp2_id", rsp_id, 1'b1);
    chk("bp2_data", rsp_data, 32'd3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // arithmetic boundaries
    do_op(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, "add_wrap");
    do_op(1'b1, 4'd7, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b0, "slt_big");
    do_op(1'b0, 4'd7, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0, "slt_true");
    do_op(1'b1, 4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "nor0");
    do_op(1'b0, 4'd9, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1, "bad9");
    do_op(1'b1, 4'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, "and");
    do_op(1'b0, 4'd6, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap");

    // reset during EXEC discards the operation
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd4; req1_b = 32'd4;
    step();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("mr_vld", rsp_valid, 1'b0);
    step();
    chk1("mr_vld_hold", rsp_valid, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("mr_vld_idle", rsp_valid, 1'b0);
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    chk1("mr_rdy0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk1("mr_id", rsp_id, 1'b0);
    chk("mr_data", rsp_data, 32'd3);
    rsp_ready = 1'b1;
    step();

    // fairness under continuous contention
    pulse_reset();
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd20; req1_b = 32'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      step();
      chk1("f_vld", rsp_valid, 1'b1);
      chk1("f_id", rsp_id, 1'(i % 2));
      chk("f_data", rsp_data, (i % 2) ? 32'd22 : 32'd11);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
